// File: rtl/arith_test_sequencer_pkg.sv
// Shared definitions for the arithmetic test sequencer: register map,
// CTRL/status bit positions and FSM state encoding.
package arith_test_sequencer_pkg;

  localparam logic [2:0] REG_CTRL       = 3'd0;
  localparam logic [2:0] REG_START_ADDR = 3'd1;
  localparam logic [2:0] REG_LENGTH     = 3'd2;
  localparam logic [2:0] REG_REPEAT     = 3'd3;
  localparam logic [2:0] REG_CYCLES     = 3'd4;
  localparam logic [2:0] REG_PASSES     = 3'd5;
  localparam logic [2:0] REG_INFO       = 3'd6;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/arith_test_sequencer_addr_pipe.sv
// Fixed-depth delay line carrying {enable, address}; reset clears every
// stage so no stale enable can emerge after a reset.
module arith_test_sequencer_addr_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             src_en,
  input  logic [WIDTH-1:0] src_addr,
  output logic             dly_en,
  output logic [WIDTH-1:0] dly_addr
);

  logic [WIDTH:0] stage [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= {src_en, src_addr};
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dly_en   = stage[DEPTH-1][WIDTH];
  assign dly_addr = stage[DEPTH-1][WIDTH-1:0];

endmodule

// File: rtl/arith_test_sequencer.sv
// Operand-address sequencer with result write re-timing, multi-pass runs,
// abort and a host-readable cycle/pass counter.
//
// state    | meaning
// ST_IDLE  | waiting for start; config registers writable
// ST_ISSUE | one operand read per cycle, passes back-to-back
// ST_DRAIN | no new reads; waiting L cycles for in-flight results
module arith_test_sequencer
  import arith_test_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_LAT    = 1,
  parameter int DUT_LAT    = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [2:0]            address,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  op_en,
  output logic [ADDR_WIDTH-1:0] op_addr,
  output logic                  res_we,
  output logic [ADDR_WIDTH-1:0] res_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int LAT = RAM_LAT + DUT_LAT;
  localparam int DW  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(LAT - 1);

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  start_addr;
  logic [CNT_WIDTH-1:0]   length, repeat_cnt, idx, passes, cycles;
  logic [DW-1:0]          drain_cnt;
  logic                   aborted;

  logic                   ctrl_wr, start_req, abort_req;
  logic [CNT_WIDTH-1:0]   idx_next, passes_next, passes_max;
  logic                   unused_bits;

  assign ctrl_wr     = write && (address == REG_CTRL);
  assign start_req   = ctrl_wr && writedata[CTRL_START];
  assign abort_req   = ctrl_wr && writedata[CTRL_ABORT];
  assign idx_next    = idx + CNT_WIDTH'(1);
  assign passes_next = passes + CNT_WIDTH'(1);
  assign passes_max  = (repeat_cnt == '0) ? CNT_WIDTH'(1) : repeat_cnt;
  assign busy        = (state != ST_IDLE);
  assign unused_bits = ^writedata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      start_addr <= '0;
      length     <= '0;
      repeat_cnt <= '0;
      idx        <= '0;
      passes     <= '0;
      cycles     <= '0;
      drain_cnt  <= '0;
      aborted    <= 1'b0;
      done       <= 1'b0;
      op_en      <= 1'b0;
      op_addr    <= '0;
    end else begin
      if (write && state == ST_IDLE) begin
        case (address)
          REG_START_ADDR: start_addr <= writedata[ADDR_WIDTH-1:0];
          REG_LENGTH:     length     <= writedata[CNT_WIDTH-1:0];
          REG_REPEAT:     repeat_cnt <= writedata[CNT_WIDTH-1:0];
          default: ;
        endcase
      end

      if (state != ST_IDLE && cycles != '1) cycles <= cycles + CNT_WIDTH'(1);

      case (state)
        ST_IDLE: begin
          if (start_req) begin
            aborted <= 1'b0;
            passes  <= '0;
            cycles  <= '0;
            idx     <= '0;
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              done    <= 1'b0;
              state   <= ST_ISSUE;
              op_en   <= 1'b1;
              op_addr <= start_addr;
            end
          end
        end
        ST_ISSUE: begin
          if (abort_req) begin
            aborted   <= 1'b1;
            op_en     <= 1'b0;
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end else if (idx_next == length) begin
            passes <= passes_next;
            if (passes_next < passes_max) begin
              // next pass starts immediately, no bubble
              idx     <= '0;
              op_addr <= start_addr;
            end else begin
              op_en     <= 1'b0;
              state     <= ST_DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end else begin
            idx     <= idx_next;
            op_addr <= start_addr + ADDR_WIDTH'(idx_next);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readdata <= '0;
    end else if (read) begin
      case (address)
        REG_CTRL:       readdata <= 32'({aborted, done, busy});
        REG_START_ADDR: readdata <= 32'(start_addr);
        REG_LENGTH:     readdata <= 32'(length);
        REG_REPEAT:     readdata <= 32'(repeat_cnt);
        REG_CYCLES:     readdata <= 32'(cycles);
        REG_PASSES:     readdata <= 32'(passes);
        REG_INFO:       readdata <= {8'd0, 8'(DUT_LAT), 8'(RAM_LAT), 8'(ADDR_WIDTH)};
        default:        readdata <= '0;
      endcase
    end
  end

  arith_test_sequencer_addr_pipe #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (LAT)
  ) u_addr_pipe (
    .clock    (clock),
    .reset    (reset),
    .src_en   (op_en),
    .src_addr (op_addr),
    .dly_en   (res_we),
    .dly_addr (res_addr)
  );

endmodule

// File: tb/tb_arith_test_sequencer.sv
// Scoreboard bench: drivers queue expected operand/result/readback events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_arith_test_sequencer;

  localparam int L = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        op_en, res_we, busy, done;
  logic [7:0]  op_addr, res_addr;

  arith_test_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .op_en     (op_en),
    .op_addr   (op_addr),
    .res_we    (res_we),
    .res_addr  (res_addr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [7:0] a;
  } ev_t;

  ev_t         op_q[$];
  ev_t         res_q[$];
  logic [31:0] rd_q[$];
  string       rd_n[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_on = 1'b0;
  bit          rd_pend = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  ev_t mon_e;
  always @(negedge clock) begin
    if (mon_on) begin
      if (op_en === 1'b1) begin
        if (op_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL op_en_unexpected: addr 0x%0h at cycle %0d, required no op_en", op_addr, cyc);
        end else begin
          mon_e = op_q.pop_front();
          chk("op_cycle", cyc, mon_e.c);
          chk("op_addr", op_addr, mon_e.a);
        end
      end
      if (res_we === 1'b1) begin
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL res_we_unexpected: addr 0x%0h at cycle %0d, required no res_we", res_addr, cyc);
        end else begin
          mon_e = res_q.pop_front();
          chk("res_cycle", cyc, mon_e.c);
          chk("res_addr", res_addr, mon_e.a);
        end
      end
      if (rd_pend && rd_q.size() > 0) chk(rd_n.pop_front(), readdata, rd_q.pop_front());
      rd_pend = (read === 1'b1);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    write = 1'b1; address = a; writedata = d;
    step();
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string n);
    read = 1'b1; address = a;
    rd_q.push_back(exp); rd_n.push_back(n);
    step();
    read = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    @(negedge clock);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic push_run(input int t, input logic [7:0] base, input int n, input int r,
                          input bit with_res);
    ev_t e;
    for (int p = 0; p < r; p++) begin
      for (int i = 0; i < n; i++) begin
        e.c = t + 1 + p * n + i;
        e.a = base + 8'(i);
        op_q.push_back(e);
        e.c = e.c + L;
        if (with_res) res_q.push_back(e);
      end
    end
  endtask

  // Full run; poke issues a start and a LENGTH write while busy, both ignored.
  task automatic run(input logic [7:0] base, input int n, input int r,
                     input logic [31:0] ctrl, input bit poke);
    int t, re, tend;
    re = (r == 0) ? 1 : r;
    wr(3'd1, 32'(base));
    wr(3'd2, n);
    wr(3'd3, r);
    t = cyc;
    tend = t + n * re + L;
    push_run(t, base, n, re, 1'b1);
    wr(3'd0, ctrl);
    if (poke) begin
      wr(3'd0, 32'd1);
      wr(3'd2, 32'd9);
    end
    wait_cyc(tend);
    chk("busy_last_drain", busy, 1);
    chk("done_last_drain", done, 0);
    wait_cyc(tend + 1);
    chk("busy_after_run", busy, 0);
    chk("done_after_run", done, 1);
    step();
  endtask

  initial begin
    int t;
    repeat (3) step();
    reset = 1'b0;
    mon_on = 1'b1;
    @(negedge clock);
    chk("rst_op_en", op_en, 0);
    chk("rst_res_we", res_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_readdata", readdata, 0);
    step();
    rd(3'd6, 32'h0002_0108, "info");
    rd(3'd0, 32'd0, "rst_ctrl");
    rd(3'd4, 32'd0, "rst_cycles");
    rd(3'd2, 32'd0, "rst_length");
    rd(3'd7, 32'd0, "reg7");

    run(8'h10, 4, 1, 32'd1, 1'b0);
    rd(3'd4, 32'd7, "t1_cycles");
    rd(3'd5, 32'd1, "t1_passes");
    rd(3'd0, 32'd2, "t1_ctrl");

    run(8'hFE, 4, 1, 32'd1, 1'b1);
    rd(3'd2, 32'd4, "wrap_length_kept");
    rd(3'd4, 32'd7, "wrap_cycles");

    run(8'h20, 3, 2, 32'd3, 1'b0);
    rd(3'd5, 32'd2, "rep2_passes");
    rd(3'd4, 32'd9, "rep2_cycles");

    run(8'h30, 2, 0, 32'd1, 1'b0);
    rd(3'd5, 32'd1, "rep0_passes");
    rd(3'd4, 32'd5, "rep0_cycles");

    // abort on the second issue cycle
    wr(3'd1, 32'h40);
    wr(3'd2, 32'd10);
    wr(3'd3, 32'd1);
    t = cyc;
    push_run(t, 8'h40, 2, 1, 1'b1);
    wr(3'd0, 32'd1);
    wr(3'd2, 32'd5);
    wr(3'd0, 32'd2);
    wait_cyc(t + 5);
    chk("abort_busy_drain", busy, 1);
    wait_cyc(t + 6);
    chk("abort_busy_end", busy, 0);
    chk("abort_done", done, 1);
    step();
    rd(3'd0, 32'd6, "abort_ctrl");
    rd(3'd5, 32'd0, "abort_passes");
    rd(3'd4, 32'd5, "abort_cycles");
    rd(3'd2, 32'd10, "abort_length_kept");

    // LENGTH=0: done immediately, never busy
    wr(3'd2, 32'd0);
    wr(3'd0, 32'd1);
    @(negedge clock);
    chk("len0_done", done, 1);
    for (int i = 0; i < 3; i++) begin
      chk("len0_busy", busy, 0);
      @(negedge clock);
    end
    step();
    rd(3'd0, 32'd2, "len0_ctrl");

    // reset during issue
    wr(3'd1, 32'h80);
    wr(3'd2, 32'd10);
    t = cyc;
    push_run(t, 8'h80, 3, 1, 1'b0);
    wr(3'd0, 32'd1);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_op_en", op_en, 0);
    chk("mid_rst_res_we", res_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    repeat (L + 2) step();
    rd(3'd2, 32'd0, "mid_rst_length");
    step();
    step();

    chk("op_q_drained", op_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
